// File: rtl/counter_core_n_pkg.sv
// Shared constants and types for the up/down counter core.
package counter_core_n_pkg;

   // Encodings of the direction and boundary-mode control inputs
   localparam logic DIR_UP    = 1'b1;
   localparam logic DIR_DOWN  = 1'b0;
   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;

   // What the counter does on a given edge, in priority order
   typedef enum logic [1:0] {
      ACT_HOLD,
      ACT_CLEAR,
      ACT_LOAD,
      ACT_STEP
   } action_e;

   // Resolve the per-edge action: clear beats load beats step; nothing moves without ena
   function automatic action_e selectAction(input logic ena, input logic clr,
                                            input logic load, input logic step);
      action_e act;
      act = ACT_HOLD;
      if (ena) begin
         if (clr)
            act = ACT_CLEAR;
         else if (load)
            act = ACT_LOAD;
         else if (step)
            act = ACT_STEP;
      end
      return act;
   endfunction

endpackage

// File: rtl/counter_core_n_prescaler.sv
// Prescaler: produces a step tick once every presc+1 enabled cycles.
module counter_core_n_prescaler #(
   parameter int PRESCALE_W = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_ena,
   input  logic                  i_restart,
   input  logic [PRESCALE_W-1:0] i_presc,
   output logic                  o_tick
);

   localparam logic [PRESCALE_W-1:0] PCNT_ONE = PRESCALE_W'(1);

   logic [PRESCALE_W-1:0] r_pcnt;
   logic                  w_reached;

   // ">=" rather than "==" so that lowering presc below the running count ticks immediately
   assign w_reached = (r_pcnt >= i_presc);
   assign o_tick    = i_ena & ~i_restart & w_reached;

   // Free-running cycle counter; frozen when disabled, restarted by clear/load or after a tick
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pcnt <= '0;
      end else if (i_ena) begin
         if (i_restart || w_reached)
            r_pcnt <= '0;
         else
            r_pcnt <= r_pcnt + PCNT_ONE;
      end
   end

endmodule

// File: rtl/counter_core_n.sv
// Parametrised up/down counter with wrap/saturate, load/clear, prescaler,
// compare match, terminal-count pulse and sticky overflow flag.
module counter_core_n
   import counter_core_n_pkg::*;
#(
   parameter int               WIDTH      = 8,
   parameter int               PRESCALE_W = 4,
   parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ena,
   input  logic                  cnt_en,
   input  logic                  up_dn,
   input  logic                  mode_sat,
   input  logic                  clr,
   input  logic                  load,
   input  logic [WIDTH-1:0]      load_val,
   input  logic [PRESCALE_W-1:0] presc,
   input  logic [WIDTH-1:0]      cmp_val,
   output logic [WIDTH-1:0]      count,
   output logic                  tc,
   output logic                  match,
   output logic                  overflow
);

   localparam logic [WIDTH-1:0] MAX_VAL  = '1;
   localparam logic [WIDTH-1:0] ZERO_VAL = '0;
   localparam logic [WIDTH-1:0] ONE_VAL  = WIDTH'(1);

   logic [WIDTH-1:0] r_count;
   logic             r_tc;
   logic             r_overflow;

   logic [WIDTH-1:0] w_countNext;
   logic             w_tcNext;
   logic             w_overflowNext;
   logic             w_restart;
   logic             w_tick;
   logic             w_boundary;
   action_e          w_action;

   // Clear or load throws away any partial prescale period
   assign w_restart = ena & (clr | load);

   counter_core_n_prescaler #(
      .PRESCALE_W (PRESCALE_W)
   ) u_prescaler (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_ena     (ena),
      .i_restart (w_restart),
      .i_presc   (presc),
      .o_tick    (w_tick)
   );

   assign w_boundary = (up_dn == DIR_UP)   ? (r_count == MAX_VAL)
                                           : (r_count == ZERO_VAL);
   assign w_action   = selectAction(ena, clr, load, w_tick & cnt_en);

   // Next count/flag values; tc defaults low so it can only pulse on a boundary step
   always_comb begin
      w_countNext    = r_count;
      w_tcNext       = 1'b0;
      w_overflowNext = r_overflow;
      case (w_action)
         ACT_CLEAR: begin
            w_countNext    = RESET_VAL;
            w_overflowNext = 1'b0;
         end
         ACT_LOAD: begin
            w_countNext    = load_val;
            w_overflowNext = 1'b0;
         end
         ACT_STEP: begin
            if (!w_boundary) begin
               w_countNext = (up_dn == DIR_UP) ? (r_count + ONE_VAL) : (r_count - ONE_VAL);
            end else begin
               if (mode_sat == MODE_WRAP)
                  w_countNext = (up_dn == DIR_UP) ? ZERO_VAL : MAX_VAL;
               w_tcNext       = 1'b1;
               w_overflowNext = 1'b1;
            end
         end
         default: begin
            w_countNext = r_count;
         end
      endcase
   end

   // Count, terminal-count pulse and sticky overflow registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count    <= RESET_VAL;
         r_tc       <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         r_count    <= w_countNext;
         r_tc       <= w_tcNext;
         r_overflow <= w_overflowNext;
      end
   end

   assign count    = r_count;
   assign tc       = r_tc;
   assign overflow = r_overflow;
   assign match    = (r_count == cmp_val);

endmodule

// File: tb/tb_counter_core_n.sv
// Bench for counter_core_n: directed vectors, a behavioural reference model
// compared on every cycle, plus literal expectations at key points.
module tb_counter_core_n;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic       cnt_en;
   logic       up_dn;
   logic       mode_sat;
   logic       clr;
   logic       load;
   logic [7:0] load_val;
   logic [3:0] presc;
   logic [7:0] cmp_val;
   logic [7:0] count;
   logic       tc;
   logic       match;
   logic       overflow;

   int checksPassed = 0;
   int checksTotal  = 0;
   bit compareOn    = 0;

   int mCount;
   int mPcnt;
   bit mTc;
   bit mOvf;

   counter_core_n #(
      .WIDTH      (8),
      .PRESCALE_W (4),
      .RESET_VAL  (8'h00)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ena      (ena),
      .cnt_en   (cnt_en),
      .up_dn    (up_dn),
      .mode_sat (mode_sat),
      .clr      (clr),
      .load     (load),
      .load_val (load_val),
      .presc    (presc),
      .cmp_val  (cmp_val),
      .count    (count),
      .tc       (tc),
      .match    (match),
      .overflow (overflow)
   );

   // 10-unit clock period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: counter value as a plain integer modulo 256
   wire mTick = (mPcnt >= int'(presc));
   wire mEdge = up_dn ? (mCount == 255) : (mCount == 0);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mCount <= 0;
         mPcnt  <= 0;
         mTc    <= 0;
         mOvf   <= 0;
      end else if (!ena) begin
         mTc <= 0;
      end else if (clr || load) begin
         mCount <= clr ? 0 : int'(load_val);
         mPcnt  <= 0;
         mTc    <= 0;
         mOvf   <= 0;
      end else begin
         mPcnt <= mTick ? 0 : mPcnt + 1;
         if (mTick && cnt_en) begin
            mTc <= mEdge;
            if (mEdge)
               mOvf <= 1;
            if (!(mEdge && mode_sat))
               mCount <= up_dn ? (mCount + 1) % 256 : (mCount + 255) % 256;
         end else begin
            mTc <= 0;
         end
      end
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checksTotal++;
      if (actual == expected)
         checksPassed++;
      else
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
   endtask

   // Compare every output against the model on each falling edge
   always @(negedge clk) begin
      if (compareOn) begin
         checkOutput("model_count", int'(count), mCount);
         checkOutput("model_tc", int'(tc), int'(mTc));
         checkOutput("model_overflow", int'(overflow), int'(mOvf));
         checkOutput("model_match", int'(match), int'(mCount == int'(cmp_val)));
      end
   end

   // Drive one cycle of controls (ena left as-is) and wait past the next falling edge
   task automatic applyStimulus(input logic cEn, input logic dir, input logic sat,
                                input logic cl, input logic ld, input logic [7:0] lv,
                                input logic [3:0] ps);
      cnt_en   = cEn;
      up_dn    = dir;
      mode_sat = sat;
      clr      = cl;
      load     = ld;
      load_val = lv;
      presc    = ps;
      @(negedge clk);
      #1;
   endtask

   task automatic checkTriple(input string name, input int expCount, input int expTc,
                              input int expOvf);
      checkOutput({name, "_count"}, int'(count), expCount);
      checkOutput({name, "_tc"}, int'(tc), expTc);
      checkOutput({name, "_overflow"}, int'(overflow), expOvf);
   endtask

   // Watchdog so the run can never hang
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n    = 1'b0;
      ena      = 1'b1;
      cnt_en   = 1'b0;
      up_dn    = 1'b1;
      mode_sat = 1'b0;
      clr      = 1'b0;
      load     = 1'b0;
      load_val = 8'h00;
      presc    = 4'd0;
      cmp_val  = 8'h55;
      #1;
      checkTriple("por", 0, 0, 0);
      @(negedge clk);
      #1;
      rst_n     = 1'b1;
      compareOn = 1;

      // Wrap up through FF with compare at 00
      $display("[TB] wrap up");
      cmp_val = 8'h00;
      applyStimulus(0, 1, 0, 0, 1, 8'hFE, 0);
      checkTriple("wrap_load", 'hFE, 0, 0);
      applyStimulus(1, 1, 0, 0, 0, 8'h00, 0);
      checkTriple("wrap_s1", 'hFF, 0, 0);
      applyStimulus(1, 1, 0, 0, 0, 8'h00, 0);
      checkTriple("wrap_s2", 'h00, 1, 1);
      checkOutput("wrap_match", int'(match), 1);
      applyStimulus(1, 1, 0, 0, 0, 8'h00, 0);
      checkTriple("wrap_s3", 'h01, 0, 1);

      // Count on to 0x37, then pull reset between edges
      $display("[TB] async reset mid-count");
      cmp_val = 8'h37;
      for (int i = 0; i < 54; i++)
         applyStimulus(1, 1, 0, 0, 0, 8'h00, 0);
      checkTriple("pre_reset", 'h37, 0, 1);
      checkOutput("pre_reset_match", int'(match), 1);
      #2;
      rst_n = 1'b0;
      #1;
      checkTriple("async_reset", 0, 0, 0);
      cnt_en = 1'b0;
      @(negedge clk);
      #1;
      rst_n = 1'b1;

      // Saturating count down into zero
      $display("[TB] saturate down");
      applyStimulus(0, 0, 1, 0, 1, 8'h02, 0);
      checkTriple("sat_load", 'h02, 0, 0);
      applyStimulus(1, 0, 1, 0, 0, 8'h00, 0);
      checkTriple("sat_s1", 'h01, 0, 0);
      applyStimulus(1, 0, 1, 0, 0, 8'h00, 0);
      checkTriple("sat_s2", 'h00, 0, 0);
      applyStimulus(1, 0, 1, 0, 0, 8'h00, 0);
      checkTriple("sat_s3", 'h00, 1, 1);
      applyStimulus(1, 0, 1, 0, 0, 8'h00, 0);
      checkTriple("sat_s4", 'h00, 1, 1);

      // Prescaler divide-by-4, then ratio lowered mid-period
      $display("[TB] prescaler");
      applyStimulus(0, 1, 0, 0, 1, 8'h10, 3);
      checkTriple("psc_load", 'h10, 0, 0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 1, 0, 0, 0, 8'h00, 3);
         checkOutput("psc_wait", int'(count), 'h10);
      end
      applyStimulus(1, 1, 0, 0, 0, 8'h00, 3);
      checkOutput("psc_tick", int'(count), 'h11);
      applyStimulus(1, 1, 0, 0, 0, 8'h00, 3);
      applyStimulus(1, 1, 0, 0, 0, 8'h00, 3);
      checkOutput("psc_pcnt2", int'(count), 'h11);
      applyStimulus(1, 1, 0, 0, 0, 8'h00, 0);
      checkOutput("psc_lowered", int'(count), 'h12);
      applyStimulus(1, 1, 0, 0, 0, 8'h00, 0);
      checkOutput("psc_every1", int'(count), 'h13);
      applyStimulus(1, 1, 0, 0, 0, 8'h00, 0);
      checkOutput("psc_every2", int'(count), 'h14);

      // Priority: clear over load, load over step and prescaler restart
      $display("[TB] priority");
      applyStimulus(0, 1, 0, 0, 1, 8'hFF, 0);
      applyStimulus(1, 1, 0, 0, 0, 8'h00, 0);
      checkTriple("pri_setovf", 'h00, 1, 1);
      applyStimulus(1, 1, 0, 1, 1, 8'hAA, 0);
      checkTriple("pri_clrload", 'h00, 0, 0);
      applyStimulus(1, 1, 0, 0, 0, 8'h00, 3);
      applyStimulus(1, 1, 0, 0, 0, 8'h00, 3);
      applyStimulus(1, 1, 0, 1'b0, 1, 8'hAA, 3);
      checkTriple("pri_load", 'hAA, 0, 0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 1, 0, 0, 0, 8'h00, 3);
         checkOutput("pri_restart_hold", int'(count), 'hAA);
      end
      applyStimulus(1, 1, 0, 0, 0, 8'h00, 3);
      checkOutput("pri_restart_tick", int'(count), 'hAB);

      // Design disable freezes everything while inputs toggle
      $display("[TB] enable freeze");
      applyStimulus(0, 1, 1, 0, 1, 8'hFF, 0);
      applyStimulus(1, 1, 1, 0, 0, 8'h00, 0);
      checkTriple("frz_pre", 'hFF, 1, 1);
      ena = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cmp_val = 8'($urandom);
         applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                       1'($urandom), 8'($urandom), 4'($urandom));
         checkTriple("frz_hold", 'hFF, 0, 1);
      end
      ena     = 1'b1;
      cmp_val = 8'hFE;
      applyStimulus(1, 0, 0, 0, 0, 8'h00, 0);
      checkTriple("frz_resume1", 'hFE, 0, 1);
      checkOutput("frz_match", int'(match), 1);
      applyStimulus(1, 0, 0, 0, 0, 8'h00, 0);
      checkTriple("frz_resume2", 'hFD, 0, 1);

      compareOn = 0;
      $display("%0d/%0d checks passed", checksPassed, checksTotal);
      $finish;
   end

endmodule
